// File: rtl/redun_mont_seq_pkg.sv
// Shared redundant-Montgomery definitions: field element and redundant word types,
// conversion helpers and a reference Montgomery multiply for modelling the external core.
package redun_mont_seq_pkg;

  localparam int unsigned WRD_BITS = 32;
  localparam int unsigned NUM_WRDS = 2;
  localparam int unsigned DAT_BITS = WRD_BITS * NUM_WRDS;
  localparam int unsigned RED_BITS = WRD_BITS + 1;

  typedef logic [DAT_BITS-1:0] fe_t;
  typedef logic [RED_BITS-1:0] rwrd_t;
  typedef rwrd_t [NUM_WRDS-1:0] redun0_t;

  // 2^64 - 59, prime; Montgomery radix R = 2^DAT_BITS
  localparam fe_t MODULUS = 64'hFFFF_FFFF_FFFF_FFC5;

  function automatic redun0_t to_redun(input fe_t x);
    redun0_t r;
    for (int i = 0; i < NUM_WRDS; i++) begin
      r[i] = {1'b0, x[i*WRD_BITS +: WRD_BITS]};
    end
    return r;
  endfunction

  function automatic fe_t from_redun(input redun0_t r);
    fe_t acc;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      acc = acc + (fe_t'(r[i]) << (i * WRD_BITS));
    end
    return acc;
  endfunction

  // Excess in the top word cannot be represented in DAT_BITS once resolved.
  function automatic logic check_overflow(input redun0_t r);
    return r[NUM_WRDS-1][WRD_BITS];
  endfunction

  // Bit-serial Montgomery product a*b*R^-1 mod MODULUS.
  function automatic fe_t mont_mul(input fe_t a, input fe_t b);
    logic [DAT_BITS+1:0] t;
    t = '0;
    for (int i = 0; i < DAT_BITS; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, MODULUS};
      t = t >> 1;
    end
    if (t >= {2'b00, MODULUS}) t = t - {2'b00, MODULUS};
    return t[DAT_BITS-1:0];
  endfunction

  function automatic fe_t to_mont(input fe_t x);
    logic [DAT_BITS:0] t;
    t = {1'b0, x};
    if (t >= {1'b0, MODULUS}) t = t - {1'b0, MODULUS};
    for (int i = 0; i < DAT_BITS; i++) begin
      t = t << 1;
      if (t >= {1'b0, MODULUS}) t = t - {1'b0, MODULUS};
    end
    return t[DAT_BITS-1:0];
  endfunction

  function automatic fe_t from_mont(input fe_t x);
    return mont_mul(x, fe_t'(1));
  endfunction

endpackage

// File: rtl/redun_mont_seq_resolve.sv
// Serial carry propagator: loads a redundant operand on start, then resolves one word
// per cycle from word 0 upward; done_o marks the cycle the last word is resolved.
module redun_carry_resolve
  import redun_mont_seq_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    start_i,
  input  redun0_t din_i,
  output logic    done_o,
  output fe_t     dout_o,
  output logic    cout_o
);

  localparam int unsigned IdxW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WRDS - 1);

  redun0_t           wrd_q;
  logic [IdxW-1:0]   idx_q;
  logic              busy_q;
  logic              carry_q;
  logic [WRD_BITS:0] sum;

  assign sum = wrd_q[idx_q] + {{WRD_BITS{1'b0}}, carry_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrd_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      wrd_q   <= din_i;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      wrd_q[idx_q] <= {1'b0, sum[WRD_BITS-1:0]};
      carry_q      <= sum[WRD_BITS];
      if (idx_q == LastIdx) begin
        busy_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign done_o = busy_q && (idx_q == LastIdx);
  assign cout_o = sum[WRD_BITS];

  // Forward the word being resolved this cycle so the consumer can latch on done_o.
  always_comb begin
    dout_o = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      dout_o[i*WRD_BITS +: WRD_BITS] = (busy_q && idx_q == IdxW'(i)) ?
                                       sum[WRD_BITS-1:0] : wrd_q[i][WRD_BITS-1:0];
    end
  end

endmodule

// File: rtl/redun_mont_seq.sv
// Sequencer for repeated Montgomery squaring on an external core: issues the operand
// T times, then resolves the redundant result into a plain field element.
module redun_mont_seq
  import redun_mont_seq_pkg::*;
#(
  parameter int unsigned T_BITS = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  fe_t               i_dat,
  input  logic [T_BITS-1:0] i_t,
  input  logic              i_val,
  output logic              o_rdy,
  output redun0_t           o_core_dat,
  output logic              o_core_val,
  input  logic              i_core_rdy,
  input  redun0_t           i_core_dat,
  input  logic              i_core_val,
  output fe_t               o_dat,
  output logic              o_val,
  input  logic              i_rdy,
  output logic [T_BITS-1:0] o_iter,
  output logic              o_ovf
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResolve,
    StOut
  } state_e;

  state_e            state_q;
  redun0_t           opnd_q;
  logic [T_BITS-1:0] t_q;
  logic [T_BITS-1:0] iter_q;
  logic [T_BITS-1:0] iter_inc;
  fe_t               dat_q;
  logic              rdy_q;
  logic              core_val_q;
  logic              val_q;
  logic              ovf_q;
  logic              rs_start_q;
  logic              rs_done;
  logic              rs_cout;
  fe_t               rs_dout;

  // iter_q < t_q whenever this is used, so it never wraps.
  assign iter_inc = iter_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      opnd_q     <= '0;
      t_q        <= '0;
      iter_q     <= '0;
      dat_q      <= '0;
      rdy_q      <= 1'b1;
      core_val_q <= 1'b0;
      val_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rs_start_q <= 1'b0;
    end else begin
      rs_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_val && rdy_q) begin
            t_q    <= i_t;
            opnd_q <= to_redun(i_dat);
            iter_q <= '0;
            ovf_q  <= 1'b0;
            rdy_q  <= 1'b0;
            if (i_t != '0) begin
              state_q    <= StIssue;
              core_val_q <= 1'b1;
            end else begin
              state_q    <= StResolve;
              rs_start_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (i_core_rdy) begin
            state_q    <= StWait;
            core_val_q <= 1'b0;
          end
        end
        StWait: begin
          if (i_core_val) begin
            opnd_q <= i_core_dat;
            iter_q <= iter_inc;
            ovf_q  <= ovf_q | check_overflow(i_core_dat);
            if (iter_inc < t_q) begin
              state_q    <= StIssue;
              core_val_q <= 1'b1;
            end else begin
              state_q    <= StResolve;
              rs_start_q <= 1'b1;
            end
          end
        end
        StResolve: begin
          if (rs_done) begin
            dat_q   <= rs_dout;
            ovf_q   <= ovf_q | rs_cout;
            val_q   <= 1'b1;
            state_q <= StOut;
          end
        end
        StOut: begin
          if (i_rdy) begin
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  redun_carry_resolve u_resolve (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (rs_start_q),
    .din_i   (opnd_q),
    .done_o  (rs_done),
    .dout_o  (rs_dout),
    .cout_o  (rs_cout)
  );

  assign o_rdy      = rdy_q;
  assign o_core_dat = opnd_q;
  assign o_core_val = core_val_q;
  assign o_dat      = dat_q;
  assign o_val      = val_q;
  assign o_iter     = iter_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_redun_mont_seq.sv
// Self-checking bench for redun_mont_seq with a latency-4 Montgomery squaring core model.
module tb_redun_mont_seq;
  import redun_mont_seq_pkg::*;

  localparam int unsigned TB = 4;
  localparam int L = 4;
  localparam int N = NUM_WRDS;

  logic          clk;
  logic          i_rst;
  fe_t           i_dat;
  logic [TB-1:0] i_t;
  logic          i_val;
  logic          o_rdy;
  redun0_t       o_core_dat;
  logic          o_core_val;
  logic          core_rdy;
  redun0_t       core_dat;
  logic          core_val;
  fe_t           o_dat;
  logic          o_val;
  logic          i_rdy;
  logic [TB-1:0] o_iter;
  logic          o_ovf;

  int errors = 0;
  int checks = 0;

  bit      force_en = 0;
  redun0_t force_dat = '0;
  bit      rdy_seen_high;
  bit      core_seen;

  typedef struct {
    longint  due;
    redun0_t dat;
  } pend_t;
  pend_t  pq[$];
  longint edge_n = 0;

  redun_mont_seq #(.T_BITS(TB)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_dat      (i_dat),
    .i_t        (i_t),
    .i_val      (i_val),
    .o_rdy      (o_rdy),
    .o_core_dat (o_core_dat),
    .o_core_val (o_core_val),
    .i_core_rdy (core_rdy),
    .i_core_dat (core_dat),
    .i_core_val (core_val),
    .o_dat      (o_dat),
    .o_val      (o_val),
    .i_rdy      (i_rdy),
    .o_iter     (o_iter),
    .o_ovf      (o_ovf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: x^(2^n) mod p with plain wide arithmetic.
  function automatic fe_t mod_sq(input fe_t x, input int n);
    logic [2*DAT_BITS-1:0] t, p;
    p = {{DAT_BITS{1'b0}}, MODULUS};
    t = {{DAT_BITS{1'b0}}, x} % p;
    for (int i = 0; i < n; i++) t = (t * t) % p;
    return t[DAT_BITS-1:0];
  endfunction

  function automatic redun0_t core_model(input redun0_t op);
    fe_t     v, r;
    redun0_t w;
    if (force_en) return force_dat;
    v = from_redun(op);
    r = mont_mul(v, v);
    w = to_redun(r);
    // Randomly shift one unit of word 1 into word 0 to exercise redundancy.
    if ($urandom_range(1) == 1 && w[1][WRD_BITS-1:0] != '0) begin
      w[1] = w[1] - 1'b1;
      w[0] = w[0] + {1'b1, {WRD_BITS{1'b0}}};
    end
    return w;
  endfunction

  initial begin
    bit      hs;
    redun0_t hs_dat;
    core_val = 0;
    core_dat = '0;
    forever begin
      @(negedge clk);
      hs     = o_core_val && core_rdy;
      hs_dat = o_core_dat;
      @(posedge clk);
      #1;
      edge_n++;
      if (hs) pq.push_back('{edge_n + L - 1, core_model(hs_dat)});
      if (pq.size() > 0 && pq[0].due == edge_n) begin
        core_val = 1;
        core_dat = pq[0].dat;
        pq.delete(0);
      end else begin
        core_val = 0;
        core_dat = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input fe_t d, input logic [TB-1:0] t, output int n);
    bit acc;
    acc = 0;
    n = 0;
    i_dat = d;
    i_t = t;
    i_val = 1;
    while (!acc && n < 50) begin
      acc = o_rdy;
      tick();
      n++;
    end
    i_val = 0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept: o_rdy=%0b after %0d cycles, required 1", o_rdy, n);
    end
  endtask

  task automatic wait_out(input int bound, output int lat, output bit ok);
    lat = 0;
    rdy_seen_high = 0;
    core_seen = 0;
    while (!o_val && lat < bound) begin
      if (o_rdy) rdy_seen_high = 1;
      if (o_core_val) core_seen = 1;
      tick();
      lat++;
    end
    ok = o_val;
  endtask

  task automatic test_reset();
    i_rst = 1;
    repeat (3) tick();
    checks += 6;
    if (o_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b need 1", o_rdy); end
    if (o_core_val !== 1'b0) begin errors++; $display("FAIL rst_cval: got %b need 0", o_core_val); end
    if (o_val !== 1'b0) begin errors++; $display("FAIL rst_val: got %b need 0", o_val); end
    if (o_iter !== '0) begin errors++; $display("FAIL rst_iter: got %0d need 0", o_iter); end
    if (o_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b need 0", o_ovf); end
    if (o_dat !== '0) begin errors++; $display("FAIL rst_dat: got %h need 0", o_dat); end
    i_rst = 0;
    tick();
  endtask

  task automatic check_job(input string nm, input fe_t d, input int t, input int lat_req);
    int  lat, n;
    bit  ok;
    fe_t exp_v;
    send_job(d, TB'(t), n);
    wait_out(400, lat, ok);
    exp_v = mod_sq(from_mont(d), t);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL %s_timeout: o_val=%b need 1", nm, o_val); end
    if (from_mont(o_dat) !== exp_v)
      begin errors++; $display("FAIL %s_dat: got %h need %h", nm, from_mont(o_dat), exp_v); end
    if (o_iter !== TB'(t)) begin errors++; $display("FAIL %s_iter: got %0d need %0d", nm, o_iter, t); end
    if (o_ovf !== 1'b0) begin errors++; $display("FAIL %s_ovf: got %b need 0", nm, o_ovf); end
    if (rdy_seen_high) begin errors++; $display("FAIL %s_rdy: o_rdy high mid-job, need 0", nm); end
    if (lat_req >= 0) begin
      checks++;
      if (lat !== lat_req) begin errors++; $display("FAIL %s_lat: got %0d need %0d", nm, lat, lat_req); end
    end
    tick();
  endtask

  task automatic test_basic();
    check_job("basic", to_mont(fe_t'(3)), 10, 10 * (L + 1) + N + 1);
  endtask

  task automatic test_t_zero();
    int lat, n;
    bit ok;
    send_job(fe_t'(64'h1234), '0, n);
    wait_out(50, lat, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL tzero_timeout: o_val=%b need 1", o_val); end
    if (o_dat !== fe_t'(64'h1234)) begin errors++; $display("FAIL tzero_dat: got %h need 1234", o_dat); end
    if (lat !== N + 1) begin errors++; $display("FAIL tzero_lat: got %0d need %0d", lat, N + 1); end
    if (core_seen) begin errors++; $display("FAIL tzero_core: o_core_val pulsed, need none"); end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      fe_t x;
      int  t;
      x = fe_t'({$urandom, $urandom}) % MODULUS;
      t = int'($urandom_range(6, 1));
      check_job("rand", x, t, t * (L + 1) + N + 1);
    end
  endtask

  task automatic test_redundant();
    redun0_t tbl[3];
    fe_t     exp_d[3];
    bit      exp_o[3];
    tbl[0] = '{33'h0_0000_0000, 33'h1_0000_0000}; exp_d[0] = 64'h1_0000_0000; exp_o[0] = 0;
    tbl[1] = '{33'h1_0000_0005, 33'h0_0000_0007}; exp_d[1] = 64'h5_0000_0007; exp_o[1] = 1;
    tbl[2] = '{33'h0_FFFF_FFFF, 33'h1_0000_0000}; exp_d[2] = 64'h0;           exp_o[2] = 1;
    force_en = 1;
    for (int k = 0; k < 3; k++) begin
      int lat, n;
      bit ok;
      force_dat = tbl[k];
      send_job(to_mont(fe_t'(7)), TB'(1), n);
      wait_out(100, lat, ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL redun%0d_timeout: o_val=%b need 1", k, o_val); end
      if (o_dat !== exp_d[k]) begin errors++; $display("FAIL redun%0d_dat: got %h need %h", k, o_dat, exp_d[k]); end
      if (o_ovf !== exp_o[k]) begin errors++; $display("FAIL redun%0d_ovf: got %b need %b", k, o_ovf, exp_o[k]); end
      tick();
    end
    force_en = 0;
  endtask

  task automatic test_core_stall();
    int      lat, n;
    bit      ok, bad;
    fe_t     x;
    redun0_t held;
    x = to_mont(fe_t'(5));
    core_rdy = 0;
    send_job(x, TB'(3), n);
    held = o_core_dat;
    checks++;
    if (held !== to_redun(x)) begin errors++; $display("FAIL stall_opnd: got %h need %h", held, to_redun(x)); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_core_val !== 1'b1 || o_core_dat !== held) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL stall_hold: val=%b dat=%h need 1/%h", o_core_val, o_core_dat, held); end
    core_rdy = 1;
    wait_out(200, lat, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL stall_timeout: o_val=%b need 1", o_val); end
    if (from_mont(o_dat) !== mod_sq(fe_t'(5), 3))
      begin errors++; $display("FAIL stall_dat: got %h need %h", from_mont(o_dat), mod_sq(fe_t'(5), 3)); end
    if (o_iter !== TB'(3)) begin errors++; $display("FAIL stall_iter: got %0d need 3", o_iter); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    send_job(to_mont(fe_t'(9)), TB'(5), n);
    tick();
    tick();
    i_rst = 1;
    tick();
    i_rst = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_val !== 1'b0 || o_iter !== '0 || o_core_val !== 1'b0 || o_rdy !== 1'b1) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rstmid_idle: val=%b iter=%0d cval=%b rdy=%b need 0/0/0/1",
               o_val, o_iter, o_core_val, o_rdy);
    end
    check_job("rstmid_next", to_mont(fe_t'(11)), 2, 2 * (L + 1) + N + 1);
  endtask

  task automatic test_out_stall();
    int  lat, n;
    bit  ok, bad;
    fe_t held;
    i_rdy = 0;
    send_job(to_mont(fe_t'(2)), TB'(1), n);
    wait_out(100, lat, ok);
    held = o_dat;
    checks++;
    if (from_mont(held) !== mod_sq(fe_t'(2), 1))
      begin errors++; $display("FAIL ostall_dat: got %h need %h", from_mont(held), mod_sq(fe_t'(2), 1)); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_val !== 1'b1 || o_dat !== held || o_rdy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL ostall_hold: val=%b dat=%h rdy=%b need 1/%h/0", o_val, o_dat, o_rdy, held); end
    i_rdy = 1;
    tick();
    checks += 2;
    if (o_val !== 1'b0) begin errors++; $display("FAIL ostall_release_val: got %b need 0", o_val); end
    if (o_rdy !== 1'b1) begin errors++; $display("FAIL ostall_release_rdy: got %b need 1", o_rdy); end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    bit ok;
    send_job(to_mont(fe_t'(13)), TB'(1), n);
    wait_out(100, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first: o_val=%b need 1", o_val); end
    send_job(to_mont(fe_t'(17)), TB'(2), n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL b2b_gap: accept after %0d cycles need 2", n); end
    wait_out(200, lat, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: o_val=%b need 1", o_val); end
    if (from_mont(o_dat) !== mod_sq(fe_t'(17), 2))
      begin errors++; $display("FAIL b2b_dat: got %h need %h", from_mont(o_dat), mod_sq(fe_t'(17), 2)); end
    tick();
  endtask

  task automatic test_max_t();
    check_job("maxt", to_mont(fe_t'(3)), (1 << TB) - 1, ((1 << TB) - 1) * (L + 1) + N + 1);
  endtask

  initial begin
    i_rst = 1;
    i_dat = '0;
    i_t = '0;
    i_val = 0;
    i_rdy = 1;
    core_rdy = 1;
    test_reset();
    test_basic();
    test_t_zero();
    test_random();
    test_redundant();
    test_core_stall();
    test_reset_mid();
    test_out_stall();
    test_back_to_back();
    test_max_t();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
